// File: rtl/err_eval_pkg.sv
// Shared types and sizing for the partition error evaluator.
package err_eval_pkg;

    localparam int unsigned DefPiW = 8;
    localparam int unsigned DefPoW = 6;

    typedef enum logic [1:0] {StIdle, StSweep, StDrain, StDone} eval_state_e;

    // Bits needed to hold a Hamming distance of 0..po_w.
    function automatic int unsigned hd_width(input int unsigned po_w);
        return $clog2(po_w + 1);
    endfunction

endpackage

// File: rtl/hd_popcount.sv
// Per-pattern Hamming distance between exact and approximate responses.
module hd_popcount
    import err_eval_pkg::*;
#(
    parameter int unsigned PO_W = DefPoW,
    localparam int unsigned HD_W = hd_width(PO_W)
) (
    input  logic [PO_W-1:0] a,
    input  logic [PO_W-1:0] b,
    output logic [HD_W-1:0] hd
);

    logic [PO_W-1:0] diff;

    assign diff = a ^ b;

    always_comb begin
        hd = '0;
        for (int i = 0; i < PO_W; i++) begin
            hd = hd + HD_W'(diff[i]);
        end
    end

endmodule

// File: rtl/part_err_eval.sv
// Exhaustive exact-vs-approximate partition sweep with error/Hamming statistics.
// Define PART_ERR_EVAL_HDMAX_EN to track the worst per-pattern distance on hd_max.
module part_err_eval
    import err_eval_pkg::*;
#(
    parameter int unsigned PI_W = DefPiW,
    parameter int unsigned PO_W = DefPoW,
    localparam int unsigned HD_W = hd_width(PO_W)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [PI_W-1:0]      pi,
    input  logic [PO_W-1:0]      po_exact,
    input  logic [PO_W-1:0]      po_approx,
    output logic                 busy,
    output logic                 done,
    output logic [PI_W:0]        err_cnt,
    output logic [PI_W+HD_W-1:0] hd_sum,
    output logic [HD_W-1:0]      hd_max
);

    localparam logic [PI_W-1:0] PiLast = '1;

    eval_state_e     state;
    logic [HD_W-1:0] hd;
    logic [HD_W-1:0] hd_q;
    logic            hd_vld_q;
    logic            clear;

    assign clear = (state == StIdle) && start;

    hd_popcount #(
        .PO_W (PO_W)
    ) u_hd_popcount (
        .a  (po_exact),
        .b  (po_approx),
        .hd (hd)
    );

    // Sweep control plus stage 1 (registered distance of the pattern on pi).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            pi       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hd_q     <= '0;
            hd_vld_q <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= StSweep;
                        pi       <= '0;
                        busy     <= 1'b1;
                        hd_q     <= '0;
                        hd_vld_q <= 1'b0;
                    end
                end
                StSweep: begin
                    hd_q     <= hd;
                    hd_vld_q <= 1'b1;
                    if (pi == PiLast) begin
                        state <= StDrain;
                    end else begin
                        pi <= pi + 1'b1;
                    end
                end
                StDrain: begin
                    hd_vld_q <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    state    <= StDone;
                end
                StDone: begin
                    done  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Stage 2: accumulate the registered distance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
            hd_sum  <= '0;
        end else if (clear) begin
            err_cnt <= '0;
            hd_sum  <= '0;
        end else if (hd_vld_q) begin
            err_cnt <= err_cnt + (PI_W + 1)'(hd_q != '0);
            hd_sum  <= hd_sum + (PI_W + HD_W)'(hd_q);
        end
    end

`ifdef PART_ERR_EVAL_HDMAX_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hd_max <= '0;
        end else if (clear) begin
            hd_max <= '0;
        end else if (hd_vld_q && (hd_q > hd_max)) begin
            hd_max <= hd_q;
        end
    end
`else
    assign hd_max = '0;
`endif

endmodule

// File: tb/tb_part_err_eval.sv
// Randomized self-checking bench for part_err_eval against a table-driven reference.
module tb_part_err_eval;

    localparam int unsigned PI_W = 8;
    localparam int unsigned PO_W = 6;
    localparam int unsigned HD_W = 3;
    localparam int unsigned NPAT = 1 << PI_W;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [PI_W-1:0]      pi;
    logic [PO_W-1:0]      po_exact;
    logic [PO_W-1:0]      po_approx;
    logic                 busy;
    logic                 done;
    logic [PI_W:0]        err_cnt;
    logic [PI_W+HD_W-1:0] hd_sum;
    logic [HD_W-1:0]      hd_max;

    logic [PO_W-1:0] exact_tbl  [NPAT];
    logic [PO_W-1:0] approx_tbl [NPAT];

    int n_vec;
    int n_miss;

    part_err_eval #(
        .PI_W (PI_W),
        .PO_W (PO_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pi        (pi),
        .po_exact  (po_exact),
        .po_approx (po_approx),
        .busy      (busy),
        .done      (done),
        .err_cnt   (err_cnt),
        .hd_sum    (hd_sum),
        .hd_max    (hd_max)
    );

    // Partitions under evaluation: pure lookup tables indexed by pi.
    assign po_exact  = exact_tbl[pi];
    assign po_approx = approx_tbl[pi];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // mode 0: identical, 1: lsb flipped everywhere, 2: all bits flipped at last pattern only,
    // 3: independent random approximation.
    task automatic fill_tables(input int mode);
        for (int p = 0; p < NPAT; p++) begin
            exact_tbl[p] = PO_W'($urandom);
            unique case (mode)
                0: approx_tbl[p] = exact_tbl[p];
                1: approx_tbl[p] = exact_tbl[p] ^ 6'b000001;
                2: approx_tbl[p] = (p == NPAT - 1) ? exact_tbl[p] ^ 6'h3F : exact_tbl[p];
                default: approx_tbl[p] = PO_W'($urandom);
            endcase
        end
    endtask

    task automatic model(output int e_err, output int e_sum, output int e_max);
        int d;
        e_err = 0;
        e_sum = 0;
        e_max = 0;
        for (int p = 0; p < NPAT; p++) begin
            d = $countones(exact_tbl[p] ^ approx_tbl[p]);
            if (d != 0) e_err++;
            e_sum += d;
            if (d > e_max) e_max = d;
        end
`ifndef PART_ERR_EVAL_HDMAX_EN
        e_max = 0;
`endif
    endtask

    // Start a sweep, watch 300 cycles, then check timing, pi sequence and results.
    task automatic run_sweep(input string tag, input bit hold);
        int done_cyc;
        int n_done;
        bit seq_ok;
        int e_err, e_sum, e_max;
        done_cyc = -1;
        n_done   = 0;
        seq_ok   = 1'b1;
        model(e_err, e_sum, e_max);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = k + 1;
            end
            // Keep start high through the DONE cycle so it must be ignored there too.
            if (hold && done_cyc > 0 && k + 1 > done_cyc) start = 1'b0;
            if (busy !== (k <= 256)) seq_ok = 1'b0;
            if (k <= 256 && pi !== PI_W'((k > 255) ? 255 : k)) seq_ok = 1'b0;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check_val({tag, "_done_cycle"}, done_cyc, 258);
        check_val({tag, "_done_count"}, n_done, 1);
        check_val({tag, "_pi_seq"}, seq_ok, 1);
        check_val({tag, "_err_cnt"}, err_cnt, e_err);
        check_val({tag, "_hd_sum"}, hd_sum, e_sum);
        check_val({tag, "_hd_max"}, hd_max, e_max);
    endtask

    initial begin
        int n_done;
        bit found;
        n_vec  = 0;
        n_miss = 0;
        start  = 1'b0;
        rst_n  = 1'b0;
        fill_tables(0);
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_pi", pi, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_err_cnt", err_cnt, 0);
        check_val("rst_hd_sum", hd_sum, 0);
        check_val("rst_hd_max", hd_max, 0);
        @(negedge clk);
        rst_n = 1'b1;

        fill_tables(0);
        run_sweep("equal", 1'b0);
        fill_tables(1);
        run_sweep("lsb_flip", 1'b0);
        fill_tables(2);
        run_sweep("last_only", 1'b0);
        fill_tables(0);
        run_sweep("start_held", 1'b1);
        for (int i = 0; i < 3; i++) begin
            fill_tables(3);
            run_sweep($sformatf("random%0d", i), 1'b0);
        end

        // Abort mid-sweep with a fresh non-trivial table so stale results would show.
        fill_tables(3);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (pi == PI_W'(100)) found = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check_val("abort_reach_pi100", found, 1);
        rst_n = 1'b0;
        #1;
        check_val("abort_pi", pi, 0);
        check_val("abort_busy", busy, 0);
        check_val("abort_done", done, 0);
        check_val("abort_err_cnt", err_cnt, 0);
        check_val("abort_hd_sum", hd_sum, 0);
        check_val("abort_hd_max", hd_max, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) n_done++;
        end
        check_val("abort_no_done", n_done, 0);
        run_sweep("after_abort", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
